// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg
//   Shared definitions for the timer controller: register addresses,
//   CTRL/STATUS bit positions, OVF counter width and the FSM state type.
//   Optional build macro used by the design: TIMER_CTRL_OVF_CNT_EN.
package timer_ctrl_pkg;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_RELOAD   = 3'd1;
    localparam logic [2:0] ADDR_PRESCALE = 3'd2;
    localparam logic [2:0] ADDR_COUNT    = 3'd3;
    localparam logic [2:0] ADDR_STATUS   = 3'd4;
    localparam logic [2:0] ADDR_OVF      = 3'd5;

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IRQ_EN   = 2;

    localparam int STAT_EXPIRED  = 0;
    localparam int STAT_RUNNING  = 1;

    localparam int OVF_WIDTH     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if
//   Configuration bus of the timer controller.
//   cfg_we     write strobe
//   cfg_addr   register address (3 bits)
//   cfg_wdata  write data (WIDTH)
//   cfg_rdata  combinational read data for cfg_addr (WIDTH)
//   irq        level interrupt
//   master: bus owner (drives writes); slave: the timer.
interface timer_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             cfg_we;
    logic [2:0]       cfg_addr;
    logic [WIDTH-1:0] cfg_wdata;
    logic [WIDTH-1:0] cfg_rdata;
    logic             irq;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata,
        input  cfg_rdata, irq
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata,
        output cfg_rdata, irq
    );
endinterface

// File: rtl/timer_prescaler.sv
// timer_prescaler
//   Free-running prescaler for the timer. Counts up while run is high and
//   pulses tick in the cycle the count equals the active limit, then wraps.
//   clk    clock
//   rst    synchronous active-high reset
//   run    advance the prescaler this cycle
//   clear  restart at zero and take a fresh limit
//   limit  programmed prescale value
//   tick   one-cycle terminal pulse
module timer_prescaler #(
    parameter int PRE_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 clear,
    input  logic [PRE_WIDTH-1:0] limit,
    output logic                 tick
);

    logic [PRE_WIDTH-1:0] cnt_q;
    logic [PRE_WIDTH-1:0] limit_q;

    // The limit is captured only at start and at each wrap, so a new
    // PRESCALE value never shortens or stretches the period in flight.
    assign tick = run && (cnt_q == limit_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            limit_q <= '0;
        end else if (clear) begin
            cnt_q   <= '0;
            limit_q <= limit;
        end else if (tick) begin
            cnt_q   <= '0;
            limit_q <= limit;
        end else if (run) begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl
//   Programmable down-counting timer with one-shot / periodic modes and a
//   level interrupt, configured through a small register file.
//   Optional build macro: TIMER_CTRL_OVF_CNT_EN adds an 8-bit saturating
//   count of expiries missed while STATUS.expired was still set (addr 5).
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  timer_ctrl_if slave: cfg_we/cfg_addr/cfg_wdata in,
//        cfg_rdata/irq out
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | stopped (reset or disabled), COUNT held
//   ST_RUN   | prescaler running, COUNT decrements on tick
//   ST_DONE  | one-shot finished; restartable like IDLE
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int PRE_WIDTH = 8
) (
    input logic         clk,
    input logic         rst,
    timer_ctrl_if.slave bus
);

    state_t               state_q;
    state_t               state_d;
    logic [2:0]           ctrl_q;
    logic [WIDTH-1:0]     reload_q;
    logic [PRE_WIDTH-1:0] prescale_q;
    logic [WIDTH-1:0]     count_q;
    logic                 expired_q;
    logic [WIDTH-1:0]     ovf_rd;

    logic running;
    logic wr_ctrl;
    logic start;
    logic stop;
    logic w1c_expired;
    logic tick;
    logic expire;
    logic decrement;

    assign running     = (state_q == ST_RUN);
    assign wr_ctrl     = bus.cfg_we && (bus.cfg_addr == ADDR_CTRL);
    assign start       = wr_ctrl && bus.cfg_wdata[CTRL_ENABLE] && !running;
    assign stop        = wr_ctrl && !bus.cfg_wdata[CTRL_ENABLE];
    assign w1c_expired = bus.cfg_we && (bus.cfg_addr == ADDR_STATUS)
                         && bus.cfg_wdata[STAT_EXPIRED];

    // A disabling write freezes COUNT, so it also swallows any tick in
    // that cycle.
    assign expire    = running && tick && !stop && (count_q == '0);
    assign decrement = running && tick && !stop && (count_q != '0);

    timer_prescaler #(
        .PRE_WIDTH (PRE_WIDTH)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .run   (running),
        .clear (start),
        .limit (prescale_q),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (expire && !ctrl_q[CTRL_PERIODIC]) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= '0;
            reload_q   <= '0;
            prescale_q <= '0;
            count_q    <= '0;
            expired_q  <= 1'b0;
        end else begin
            if (bus.cfg_we && (bus.cfg_addr == ADDR_RELOAD)) begin
                reload_q <= bus.cfg_wdata;
            end
            if (bus.cfg_we && (bus.cfg_addr == ADDR_PRESCALE)) begin
                prescale_q <= bus.cfg_wdata[PRE_WIDTH-1:0];
            end

            // While running, enable is already 1 and stays 1 unless the
            // write clears it, so a plain copy covers start, stop and
            // mode updates alike.
            if (wr_ctrl) begin
                ctrl_q <= bus.cfg_wdata[2:0];
            end
            if (expire && !ctrl_q[CTRL_PERIODIC]) begin
                ctrl_q[CTRL_ENABLE] <= 1'b0;
            end

            if (start) begin
                count_q <= reload_q;
            end else if (expire && ctrl_q[CTRL_PERIODIC]) begin
                count_q <= reload_q;
            end else if (decrement) begin
                count_q <= count_q - 1'b1;
            end

            if (expire) begin
                expired_q <= 1'b1;
            end else if (w1c_expired) begin
                expired_q <= 1'b0;
            end
        end
    end

`ifdef TIMER_CTRL_OVF_CNT_EN
    logic [OVF_WIDTH-1:0] ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
        end else if (expire && expired_q) begin
            if (ovf_q != '1) begin
                ovf_q <= ovf_q + 1'b1;
            end
        end else if (w1c_expired && !expire) begin
            ovf_q <= '0;
        end
    end

    assign ovf_rd = WIDTH'(ovf_q);
`else
    assign ovf_rd = '0;
`endif

    always_comb begin
        bus.cfg_rdata = '0;
        case (bus.cfg_addr)
            ADDR_CTRL:     bus.cfg_rdata = WIDTH'(ctrl_q);
            ADDR_RELOAD:   bus.cfg_rdata = reload_q;
            ADDR_PRESCALE: bus.cfg_rdata = WIDTH'(prescale_q);
            ADDR_COUNT:    bus.cfg_rdata = count_q;
            ADDR_STATUS:   bus.cfg_rdata = WIDTH'({running, expired_q});
            ADDR_OVF:      bus.cfg_rdata = ovf_rd;
            default:       bus.cfg_rdata = '0;
        endcase
    end

    assign bus.irq = expired_q && ctrl_q[CTRL_IRQ_EN];

endmodule
